// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI frame layout, FSM encoding and frame builder
package spi_pkg;

    localparam int unsigned FRAME_BITS = 16;

    // Frame field positions, MSB transmitted first
    localparam int unsigned RW_BIT  = 15;
    localparam int unsigned EXT_MSB = 14;
    localparam int unsigned EXT_LSB = 12;
    localparam int unsigned RSV_BIT = 11;
    localparam int unsigned REG_MSB = 10;
    localparam int unsigned REG_LSB = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } spi_state_e;

    // Assemble a frame; reads carry no payload so the data byte is zeroed
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic       rw,
        input logic [2:0] ext_addr,
        input logic [2:0] reg_addr,
        input logic [7:0] wdata
    );
        logic [FRAME_BITS-1:0] f;
        f                   = '0;
        f[RW_BIT]           = rw;
        f[EXT_MSB:EXT_LSB]  = ext_addr;
        f[RSV_BIT]          = 1'b0;
        f[REG_MSB:REG_LSB]  = reg_addr;
        f[REG_LSB-1:0]      = rw ? 8'h00 : wdata;
        return f;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - SPI half-period tick generator
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [7:0] TERM = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Count while enabled, wrap at the half-period, restart from zero when disabled
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q == TERM) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == TERM);

endmodule

// File: rtl/spi_master_frame.sv
// rtl/spi_master_frame.sv - fixed 16-bit SPI mode-0 frame master
module spi_master_frame #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned FRAME_BITS = 16
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [2:0] ext_addr,
    input  logic [2:0] reg_addr,
    input  logic [7:0] wdata,
    input  logic       miso,
    input  logic       miso_oe,
    output logic       spi_sck,
    output logic       cs,
    output logic       mosi,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata
);

    import spi_pkg::*;

    // Two toggles per bit; the counter ends on the final falling toggle
    localparam logic [4:0] LAST_TOGGLE = 5'(2 * FRAME_BITS - 1);

    spi_state_e            state_q, state_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [4:0]            tog_q,   tog_d;
    logic                  sck_q,   sck_d;
    logic                  mosi_q,  mosi_d;
    logic                  rw_q,    rw_d;
    logic [7:0]            rdata_q, rdata_d;
    logic [FRAME_BITS-1:0] frame;
    logic                  active;
    logic                  tick;

    assign active = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
    assign frame  = build_frame(rw, ext_addr, reg_addr, wdata);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk_i  (sclk),
        .rst_i  (rst),
        .en_i   (active),
        .tick_o (tick)
    );

    // Frame sequencing: the shift register transmits from its MSB and
    // receives into its LSB, so after 16 rising edges it holds the reply
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        tog_d   = tog_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        rw_d    = rw_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rw_d    = rw;
                    shreg_d = frame;
                    mosi_d  = frame[RW_BIT];
                    sck_d   = 1'b0;
                    tog_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    tog_d = tog_q + 5'd1;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        // rising toggle: sample, undriven line reads as 0
                        shreg_d = {shreg_q[FRAME_BITS-2:0], miso & miso_oe};
                    end else if (tog_q != LAST_TOGGLE) begin
                        // falling toggle: present the next frame bit
                        mosi_d = shreg_q[FRAME_BITS-1];
                    end
                    if (tog_q == LAST_TOGGLE) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    mosi_d  = 1'b0;
                    state_d = ST_DONE;
                    if (rw_q) begin
                        rdata_d = shreg_q[REG_LSB-1:0];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            tog_q   <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            rw_q    <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            tog_q   <= tog_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            rw_q    <= rw_d;
            rdata_q <= rdata_d;
        end
    end

    assign spi_sck = sck_q;
    assign cs      = active;
    assign busy    = active;
    assign done    = (state_q == ST_DONE);
    assign mosi    = mosi_q;
    assign rdata   = rdata_q;

endmodule
